// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN result-drain path.
package cnn_pkg;

  localparam int BUS_W      = 32;
  localparam int SENT_CNT_W = 16;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_COL    = 32;
  localparam int LPB        = BUS_W / DEF_WIDTH;
  localparam int BEATS      = DEF_COL * DEF_WIDTH / BUS_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } out_state_e;

  function automatic int lanes_per_beat(input int w);
    return BUS_W / w;
  endfunction

  function automatic int beats_per_vec(input int w, input int c);
    return c * w / BUS_W;
  endfunction

endpackage

// File: rtl/cnn_out_packer_buf.sv
// Two-slot result vector store; each slot is kept as bus-wide beat words so the
// read port is a plain word select by slot and beat index.
module out_vec_buf
  import cnn_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int col   = DEF_COL,
  parameter int lpb   = LPB,
  parameter int beats = BEATS,
  parameter int kw    = (beats > 1) ? $clog2(beats) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_slot,
  input  logic [width-1:0] wr_vec [col],
  input  logic             rd_slot,
  input  logic [kw-1:0]    rd_beat,
  output logic [BUS_W-1:0] rd_data
);

  // Sized to a power of two so the beat index never needs truncation.
  logic [BUS_W-1:0] mem [2][2**kw];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < beats; b++) begin
        for (int j = 0; j < lpb; j++) begin
          mem[wr_slot][b][j*width +: width] <= wr_vec[b*lpb + j];
        end
      end
    end
  end

  assign rd_data = mem[rd_slot][rd_beat];

endmodule

// File: rtl/cnn_out_packer.sv
// Result-drain packer: ping-pong captures result vectors and streams them out
// as 32-bit beats on a valid/ready master port.
//
// state | meaning
// IDLE  | no buffered vector, m_valid_o low
// SEND  | presenting beat k of slot rd_ptr
module cnn_out_packer
  import cnn_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int col   = DEF_COL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [width-1:0]      vec_i [col],
  input  logic                  vec_vld_i,
  output logic                  vec_rdy_o,
  output logic [BUS_W-1:0]      m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  ovf_o,
  output logic [SENT_CNT_W-1:0] sent_cnt_o
);

  localparam int lpb_p   = lanes_per_beat(width);
  localparam int beats_p = beats_per_vec(width, col);
  localparam int kw      = (beats_p > 1) ? $clog2(beats_p) : 1;
  localparam logic [kw-1:0] k_last = kw'(beats_p - 1);

  out_state_e       state;
  logic [1:0]       count;
  logic [1:0]       count_n;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [kw-1:0]    k;
  logic             push;
  logic             pop;
  logic             last_pop;
  logic [BUS_W-1:0] rd_data;

  assign push     = vec_vld_i & vec_rdy_o;
  assign pop      = m_valid_o & m_ready_i;
  assign last_pop = pop & (k == k_last);
  assign count_n  = count + {1'b0, push} - {1'b0, last_pop};

  // Gated so stale slot contents never show on the bus outside a beat.
  assign m_data_o = m_valid_o ? rd_data : '0;
  assign m_last_o = m_valid_o & (k == k_last);

  out_vec_buf #(
    .width (width),
    .col   (col),
    .lpb   (lpb_p),
    .beats (beats_p),
    .kw    (kw)
  ) u_buf (
    .clk     (clk),
    .wr_en   (push),
    .wr_slot (wr_ptr),
    .wr_vec  (vec_i),
    .rd_slot (rd_ptr),
    .rd_beat (k),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      k          <= '0;
      vec_rdy_o  <= 1'b1;
      m_valid_o  <= 1'b0;
      ovf_o      <= 1'b0;
      sent_cnt_o <= '0;
    end else begin
      count     <= count_n;
      vec_rdy_o <= (count_n < 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (vec_vld_i && !vec_rdy_o) ovf_o <= 1'b1;
      case (state)
        IDLE: begin
          // Leave on the push edge itself so beat 0 is valid the next cycle.
          if (count_n != 2'd0) begin
            state     <= SEND;
            m_valid_o <= 1'b1;
            k         <= '0;
          end
        end
        SEND: begin
          if (last_pop) begin
            k          <= '0;
            rd_ptr     <= ~rd_ptr;
            sent_cnt_o <= sent_cnt_o + SENT_CNT_W'(1);
            if (count_n == 2'd0) begin
              state     <= IDLE;
              m_valid_o <= 1'b0;
            end
          end else if (pop) begin
            k <= k + kw'(1);
          end
        end
        default: begin
          state     <= IDLE;
          m_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_out_packer.sv
// Directed bench for cnn_out_packer: main instance at 16x32, second instance at
// one beat per vector for the sent counter wrap.
module tb_cnn_out_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] vec [32];
  logic        vec_vld;
  logic        vec_rdy;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        ovf;
  logic [15:0] sent;

  logic        rst2;
  logic [31:0] vec2 [1];
  logic        vld2;
  logic        rdy2;
  logic [31:0] data2;
  logic        valid2;
  logic        ready2;
  logic        last2;
  logic        ovf2;
  logic [15:0] sent2;

  cnn_out_packer #(.width(16), .col(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .vec_i      (vec),
    .vec_vld_i  (vec_vld),
    .vec_rdy_o  (vec_rdy),
    .m_data_o   (m_data),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_last_o   (m_last),
    .ovf_o      (ovf),
    .sent_cnt_o (sent)
  );

  cnn_out_packer #(.width(32), .col(1)) dut_wrap (
    .clk        (clk),
    .rst        (rst2),
    .vec_i      (vec2),
    .vec_vld_i  (vld2),
    .vec_rdy_o  (rdy2),
    .m_data_o   (data2),
    .m_valid_o  (valid2),
    .m_ready_i  (ready2),
    .m_last_o   (last2),
    .ovf_o      (ovf2),
    .sent_cnt_o (sent2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] base);
    for (int i = 0; i < 32; i++) vec[i] = base + 16'(i);
  endtask

  task automatic do_reset;
    rst     = 1'b1;
    vec_vld = 1'b0;
    m_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] exp_beat(input logic [15:0] base, input int b);
    logic [15:0] lo;
    lo = base + 16'(2 * b);
    return {lo + 16'd1, lo};
  endfunction

  task automatic stream_vec(input string tag, input logic [15:0] base);
    m_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      chk({tag, "_valid"}, m_valid, 1);
      chk({tag, "_data"}, m_data, exp_beat(base, b));
      chk({tag, "_last"}, m_last, b == 15);
      tick;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          idx, cyc, n, seen, accepted, pops, bad;
    logic        stalled, plast, mark;
    logic [31:0] pdata;

    rst2 = 1'b1;
    vld2 = 1'b0;
    ready2 = 1'b0;
    vec2[0] = '0;
    load(16'h0000);

    // reset values
    do_reset;
    chk("rst_rdy", vec_rdy, 1);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", m_data, 0);
    chk("rst_sent", sent, 0);

    // single vector, ready held high
    load(16'h0100);
    vec_vld = 1'b1;
    m_ready = 1'b1;
    tick;
    vec_vld = 1'b0;
    for (int b = 0; b < 16; b++) begin
      chk("t1_valid", m_valid, 1);
      chk("t1_data", m_data, exp_beat(16'h0100, b));
      chk("t1_last", m_last, b == 15);
      if (b == 0)  chk("t1_beat0", m_data, 32'h0101_0100);
      if (b == 15) chk("t1_beat15", m_data, 32'h011F_011E);
      tick;
    end
    chk("t1_idle", m_valid, 0);
    chk("t1_sent", sent, 1);

    // random backpressure
    load(16'h0200);
    vec_vld = 1'b1;
    m_ready = 1'b0;
    tick;
    vec_vld = 1'b0;
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    pdata = '0;
    plast = 1'b0;
    while (idx < 16 && cyc < 200) begin
      m_ready = 1'($urandom_range(0, 1));
      if (stalled) begin
        chk("t2_hold_valid", m_valid, 1);
        chk("t2_hold_data", m_data, pdata);
        chk("t2_hold_last", m_last, plast);
      end
      if (m_valid && m_ready) begin
        chk("t2_data", m_data, exp_beat(16'h0200, idx));
        chk("t2_last", m_last, idx == 15);
        idx++;
      end
      stalled = m_valid && !m_ready;
      pdata = m_data;
      plast = m_last;
      tick;
      cyc++;
    end
    chk("t2_beats", idx, 16);
    chk("t2_idle", m_valid, 0);
    chk("t2_sent", sent, 2);

    // three pushes with host stalled: third dropped
    do_reset;
    load(16'h0300);
    vec_vld = 1'b1;
    chk("t3_rdy_a", vec_rdy, 1);
    tick;
    load(16'h0400);
    chk("t3_rdy_b", vec_rdy, 1);
    tick;
    load(16'h0500);
    chk("t3_rdy_c", vec_rdy, 0);
    chk("t3_ovf_pre", ovf, 0);
    tick;
    vec_vld = 1'b0;
    chk("t3_ovf", ovf, 1);
    chk("t3_rdy_d", vec_rdy, 0);
    m_ready = 1'b1;
    n = 0;
    while (m_valid && n < 40) begin
      chk("t3_data", m_data, exp_beat((n < 16) ? 16'h0300 : 16'h0400, n % 16));
      chk("t3_last", m_last, (n % 16) == 15);
      n++;
      tick;
    end
    chk("t3_beats", n, 32);
    chk("t3_sent", sent, 2);
    chk("t3_ovf_hold", ovf, 1);
    chk("t3_rdy_end", vec_rdy, 1);

    // push on last-pop with one vector buffered: no bubble
    load(16'h0600);
    vec_vld = 1'b1;
    m_ready = 1'b1;
    tick;
    vec_vld = 1'b0;
    for (int b = 0; b < 16; b++) begin
      chk("t4a_data", m_data, exp_beat(16'h0600, b));
      if (b == 15) begin
        load(16'h0700);
        vec_vld = 1'b1;
        chk("t4a_rdy", vec_rdy, 1);
      end
      tick;
    end
    vec_vld = 1'b0;
    chk("t4a_nobubble", m_data, exp_beat(16'h0700, 0));
    chk("t4a_rdy_after", vec_rdy, 1);
    chk("t4a_sent", sent, 3);
    stream_vec("t4a_b", 16'h0700);
    chk("t4a_idle", m_valid, 0);
    chk("t4a_sent2", sent, 4);

    // push on last-pop with two vectors buffered: ready low, vector dropped
    do_reset;
    load(16'h0A00);
    vec_vld = 1'b1;
    tick;
    load(16'h0B00);
    tick;
    vec_vld = 1'b0;
    chk("t4b_rdy_full", vec_rdy, 0);
    m_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      chk("t4b_data", m_data, exp_beat(16'h0A00, b));
      if (b == 15) begin
        chk("t4b_rdy_last", vec_rdy, 0);
        load(16'h0C00);
        vec_vld = 1'b1;
      end
      tick;
    end
    vec_vld = 1'b0;
    chk("t4b_ovf", ovf, 1);
    chk("t4b_rdy_after", vec_rdy, 1);
    stream_vec("t4b_b", 16'h0B00);
    chk("t4b_idle", m_valid, 0);
    tick;
    chk("t4b_still_idle", m_valid, 0);
    chk("t4b_sent", sent, 2);

    // reset mid-vector with a second vector buffered
    do_reset;
    load(16'h0800);
    vec_vld = 1'b1;
    tick;
    load(16'h0900);
    tick;
    load(16'h0D00);
    tick;
    vec_vld = 1'b0;
    chk("t5_ovf_set", ovf, 1);
    m_ready = 1'b1;
    for (int b = 0; b < 7; b++) begin
      chk("t5_data", m_data, exp_beat(16'h0800, b));
      tick;
    end
    chk("t5_beat7", m_data, exp_beat(16'h0800, 7));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t5_valid", m_valid, 0);
    chk("t5_data0", m_data, 0);
    chk("t5_last", m_last, 0);
    chk("t5_rdy", vec_rdy, 1);
    chk("t5_ovf", ovf, 0);
    chk("t5_sent", sent, 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      m_ready = 1'(c % 2);
      if (m_valid || m_last) seen++;
      tick;
    end
    chk("t5_quiet", seen, 0);

    // sent counter wrap on the one-beat instance
    rst2 = 1'b1;
    tick;
    rst2 = 1'b0;
    ready2 = 1'b1;
    accepted = 0;
    pops = 0;
    bad = 0;
    cyc = 0;
    while (pops < 65537 && cyc < 70000) begin
      vld2 = (accepted < 65537);
      vec2[0] = 32'(accepted);
      if (vld2 && rdy2) accepted++;
      mark = 1'b0;
      if (valid2) begin
        if (data2 !== 32'(pops) || last2 !== 1'b1) bad++;
        pops++;
        mark = (pops == 65536);
      end
      tick;
      cyc++;
      if (mark) chk("t6_wrap0", sent2, 0);
    end
    vld2 = 1'b0;
    chk("t6_pops", pops, 65537);
    chk("t6_data", bad, 0);
    chk("t6_sent", sent2, 1);
    chk("t6_idle", valid2, 0);
    chk("t6_ovf", ovf2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
